// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle around fifo_rd_stream: FIFO read port on one side and a valid/ready stream on the other.
// master = the reader; slave = the environment (FIFO plus downstream consumer).
interface fifo_rd_stream_if #(
    parameter int WIDTH_DATA = 8
);
    logic                  fifo_rd_en;
    logic [WIDTH_DATA-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic [WIDTH_DATA-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        output m_valid,
        output m_data,
        input  fifo_rd_data,
        input  fifo_empty,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        output fifo_rd_data,
        output fifo_empty,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Streams words out of a fixed-latency FIFO read port as valid/ready data, absorbing the read
// latency in a small circular buffer so the consumer can stall at any time without loss.
module fifo_rd_stream #(
    parameter  int WIDTH_DATA = 8,
    parameter  int REG_OUT    = 0,
    localparam int RD_LAT     = 1 + REG_OUT,
    localparam int SKID_DEPTH = RD_LAT + 2,
    localparam int LEVEL_W    = $clog2(SKID_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    fifo_rd_stream_if.master   bus,
    output logic [LEVEL_W-1:0] level,
    output logic               err_ovf
);
    localparam int                 PTR_W    = $clog2(SKID_DEPTH);
    localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(SKID_DEPTH - 1);

    logic [RD_LAT-1:0]     inflight_q;
    logic [RD_LAT-1:0]     inflight_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [LEVEL_W-1:0]    cnt_q;
    logic [LEVEL_W-1:0]    cnt_d;
    logic [LEVEL_W-1:0]    level_q;
    logic [LEVEL_W-1:0]    level_d;
    logic                  err_q;
    logic                  err_d;
    logic [WIDTH_DATA-1:0] buf_q [SKID_DEPTH];

    logic issue;
    logic arrive;
    logic pop;
    logic buf_empty;
    logic buf_full;
    logic wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // level counts words already promised a slot, so requesting only below SKID_DEPTH
    // guarantees every arrival finds room even if the consumer stalls from now on.
    assign issue     = !rst && !bus.fifo_empty && (level_q < DEPTH_L);
    assign arrive    = inflight_q[RD_LAT-1];
    assign buf_empty = (cnt_q == '0);
    assign buf_full  = (cnt_q == DEPTH_L);
    assign pop       = !buf_empty && bus.m_ready;
    assign wr_en     = arrive && (!buf_full || pop);

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign inflight_d = issue;
        end else begin : g_latn
            assign inflight_d = {inflight_q[RD_LAT-2:0], issue};
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        cnt_d = cnt_q;
        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + LEVEL_W'(1);
            2'b01:   cnt_d = cnt_q - LEVEL_W'(1);
            default: cnt_d = cnt_q;
        endcase

        level_d = level_q;
        unique case ({issue, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase

        err_d = err_q || (arrive && buf_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            err_q      <= err_d;
        end
    end

    // Entries are cleared on reset so m_data reads zero while nothing has been buffered.
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (rst) begin
                buf_q[gi] <= '0;
            end else if (wr_en && (wr_ptr_q == PTR_W'(gi))) begin
                buf_q[gi] <= bus.fifo_rd_data;
            end
        end
    end

    assign bus.fifo_rd_en = issue;
    assign bus.m_valid    = !buf_empty;
    assign bus.m_data     = buf_q[rd_ptr_q];
    assign level          = level_q;
    assign err_ovf        = err_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Runs REG_OUT=0 and REG_OUT=1 readers side by side on identical stimulus, each against its own
// FIFO model, with a scoreboard and cycle-level rules derived from the read latency.
module tb_fifo_rd_stream;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_push;
    logic [7:0] wr_data;
    logic       m_ready;
    logic       hold;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    logic       rd_en_w [2];
    logic       vld_w   [2];
    logic [7:0] data_w  [2];
    logic [3:0] lvl_w   [2];
    logic       err_w   [2];
    int         req_w   [2];
    int         frd_w   [2];
    int         fvl_w   [2];
    int         beats_w [2];
    int         gaps_w  [2];
    int         badrd_w [2];
    int         outst_w [2];
    int         fill_w  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RO   = gi;
        localparam int LAT  = 1 + RO;
        localparam int SKID = LAT + 2;

        fifo_rd_stream_if #(.WIDTH_DATA(W)) ifc ();
        logic [$clog2(SKID+1)-1:0] level;
        logic                      err_ovf;

        fifo_rd_stream #(.WIDTH_DATA(W), .REG_OUT(RO)) dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (ifc),
            .level   (level),
            .err_ovf (err_ovf)
        );

        // FIFO model: data appears LAT cycles after the request, held until the next read.
        logic [7:0] fmem    [256];
        logic [7:0] exp_mem [1024];
        int         wp, rp, push_n;
        logic [7:0] d1, d2;

        always @(posedge clk) begin
            if (rst) begin
                wp <= 0; rp <= 0; push_n <= 0; d1 <= '0; d2 <= '0;
            end else begin
                if (wr_push) begin
                    fmem[wp[7:0]]      <= wr_data;
                    exp_mem[push_n % 1024] <= wr_data;
                    wp     <= wp + 1;
                    push_n <= push_n + 1;
                end
                if (ifc.fifo_rd_en) begin
                    d1 <= fmem[rp[7:0]];
                    rp <= rp + 1;
                end
                d2 <= d1;
            end
        end

        assign ifc.fifo_empty   = (wp == rp) || hold;
        assign ifc.fifo_rd_data = (LAT == 1) ? d1 : d2;
        assign ifc.m_ready      = m_ready;

        // Reference rules: a word requested in cycle c is visible from cycle c+LAT+1,
        // level = requests - pops, requests only while non-empty and level < SKID.
        int         req_n, frd, fvl, beats, gaps, bad_rd, pop_n, arr_n, mlevel, last_beat;
        logic [2:0] rh;
        logic       prev_stall;
        logic [7:0] prev_data;

        always @(negedge clk) begin
            if (rst) begin
                req_n = 0; frd = -1; fvl = -1; beats = 0; gaps = 0; bad_rd = 0;
                pop_n = 0; arr_n = 0; mlevel = 0; last_beat = -1; rh = '0;
                prev_stall = 1'b0; prev_data = '0;
            end else begin
                chk($sformatf("level_r%0d", RO), level, mlevel);
                chk($sformatf("rd_en_rule_r%0d", RO), ifc.fifo_rd_en,
                    (wp != rp) && !hold && (mlevel < SKID));
                arr_n += int'(rh[LAT]);
                chk($sformatf("m_valid_r%0d", RO), ifc.m_valid, arr_n > pop_n);
                if (prev_stall) begin
                    chk($sformatf("stall_valid_r%0d", RO), ifc.m_valid, 1);
                    chk($sformatf("stall_data_r%0d", RO), ifc.m_data, prev_data);
                end
                if (ifc.fifo_rd_en) begin
                    req_n++;
                    if (frd < 0) frd = cyc;
                    if (wp == rp) bad_rd++;
                end
                if (ifc.m_valid && fvl < 0) fvl = cyc;
                if (ifc.m_valid && m_ready) begin
                    chk($sformatf("beat_backed_r%0d", RO), pop_n < push_n, 1);
                    if (pop_n < push_n)
                        chk($sformatf("beat_data_r%0d", RO), ifc.m_data, exp_mem[pop_n % 1024]);
                    pop_n++;
                    beats++;
                    if (last_beat >= 0 && cyc != last_beat + 1) gaps++;
                    last_beat = cyc;
                end
                mlevel += int'(ifc.fifo_rd_en) - int'(ifc.m_valid && m_ready);
                rh = {rh[1:0], ifc.fifo_rd_en};
                prev_stall = ifc.m_valid && !m_ready;
                prev_data  = ifc.m_data;
            end
        end

        assign rd_en_w[gi] = ifc.fifo_rd_en;
        assign vld_w[gi]   = ifc.m_valid;
        assign data_w[gi]  = ifc.m_data;
        assign lvl_w[gi]   = 4'(level);
        assign err_w[gi]   = err_ovf;
        assign req_w[gi]   = req_n;
        assign frd_w[gi]   = frd;
        assign fvl_w[gi]   = fvl;
        assign beats_w[gi] = beats;
        assign gaps_w[gi]  = gaps;
        assign badrd_w[gi] = bad_rd;
        assign outst_w[gi] = push_n - pop_n;
        assign fill_w[gi]  = wp - rp;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            wr_push = 1'b1;
            wr_data = base + 8'(k);
            tick();
        end
        wr_push = 1'b0;
    endtask

    int   vcnt [2];
    int   snap [2];
    logic found;
    int   wr_pct, rd_pct;

    initial begin
        rst = 1'b1; wr_push = 1'b0; wr_data = '0; m_ready = 1'b1; hold = 1'b0;

        // Reset and idle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst_rd_en_r%0d", i), rd_en_w[i], 0);
                chk($sformatf("rst_valid_r%0d", i), vld_w[i], 0);
                chk($sformatf("rst_level_r%0d", i), lvl_w[i], 0);
                chk($sformatf("rst_data_r%0d", i), data_w[i], 0);
                chk($sformatf("rst_err_r%0d", i), err_w[i], 0);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle_rd_en_r%0d", i), rd_en_w[i], 0);
                chk($sformatf("idle_valid_r%0d", i), vld_w[i], 0);
                chk($sformatf("idle_level_r%0d", i), lvl_w[i], 0);
            end
        end

        // Streaming: 16 preloaded words, consumer always ready
        do_reset();
        m_ready = 1'b1; hold = 1'b1;
        preload(16, 8'h00);
        hold = 1'b0;
        repeat (30) tick();
        for (int i = 0; i < 2; i++) begin
            // m_valid rises on the RD_LAT-th edge after the edge that samples the first rd_en
            chk($sformatf("first_lat_r%0d", i), fvl_w[i] - frd_w[i], i + 2);
            chk($sformatf("stream_beats_r%0d", i), beats_w[i], 16);
            chk($sformatf("stream_gaps_r%0d", i), gaps_w[i], 0);
            chk($sformatf("stream_outst_r%0d", i), outst_w[i], 0);
            chk($sformatf("stream_err_r%0d", i), err_w[i], 0);
        end

        // Backpressure: consumer stalled for 20 cycles, then released
        do_reset();
        m_ready = 1'b0; hold = 1'b1;
        preload(16, 8'h00);
        hold = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bp_requests_r%0d", i), req_w[i], 3 + i);
            chk($sformatf("bp_level_r%0d", i), lvl_w[i], 3 + i);
            chk($sformatf("bp_valid_r%0d", i), vld_w[i], 1);
            chk($sformatf("bp_data_r%0d", i), data_w[i], 0);
            chk($sformatf("bp_rd_en_r%0d", i), rd_en_w[i], 0);
        end
        m_ready = 1'b1;
        repeat (30) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bp_beats_r%0d", i), beats_w[i], 16);
            chk($sformatf("bp_gaps_r%0d", i), gaps_w[i], 0);
            chk($sformatf("bp_outst_r%0d", i), outst_w[i], 0);
            chk($sformatf("bp_err_r%0d", i), err_w[i], 0);
        end

        // Drain to empty: two words only
        do_reset();
        m_ready = 1'b1;
        preload(2, 8'hA0);
        repeat (15) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("drain_beats_r%0d", i), beats_w[i], 2);
            chk($sformatf("drain_requests_r%0d", i), req_w[i], 2);
            chk($sformatf("drain_bad_rd_r%0d", i), badrd_w[i], 0);
            chk($sformatf("drain_rd_en_r%0d", i), rd_en_w[i], 0);
            chk($sformatf("drain_valid_r%0d", i), vld_w[i], 0);
        end

        // Reset the cycle after a request
        do_reset();
        m_ready = 1'b1;
        preload(4, 8'h50);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (rd_en_w[0]) found = 1'b1;
            else tick();
        end
        chk("mid_rd_seen", found, 1);
        tick();
        do_reset();
        vcnt[0] = 0; vcnt[1] = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 2; i++) if (vld_w[i]) vcnt[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid_valid_cnt_r%0d", i), vcnt[i], 0);
            chk($sformatf("mid_level_r%0d", i), lvl_w[i], 0);
        end

        // Random soak: writer and consumer at 50% / 100%
        for (int combo = 0; combo < 4; combo++) begin
            wr_pct = combo[1] ? 100 : 50;
            rd_pct = combo[0] ? 100 : 50;
            do_reset();
            for (int c = 0; c < 5000; c++) begin
                wr_push = ($urandom_range(99) < wr_pct) && (fill_w[0] < 200) && (fill_w[1] < 200);
                wr_data = 8'($urandom);
                m_ready = ($urandom_range(99) < rd_pct);
                tick();
            end
            snap[0] = beats_w[0]; snap[1] = beats_w[1];
            wr_push = 1'b0; m_ready = 1'b1;
            repeat (300) tick();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("soak%0d_outst_r%0d", combo, i), outst_w[i], 0);
                chk($sformatf("soak%0d_fill_r%0d", combo, i), fill_w[i], 0);
                chk($sformatf("soak%0d_err_r%0d", combo, i), err_w[i], 0);
                chk($sformatf("soak%0d_bad_rd_r%0d", combo, i), badrd_w[i], 0);
                if (wr_pct == 100 && rd_pct == 100)
                    chk($sformatf("soak_throughput_r%0d", i), snap[i] >= 4990, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
